// File: rtl/pipe_mux_skid.sv
// pipe_mux_skid: registered N-to-1 select stage with valid/ready handshake, one-entry skid buffer and flush
module pipe_mux_skid #(
  parameter int WIDTH = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d, err_q, err_d;
  logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, sel_val;
  logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
  logic             sel_ok, accept;
  assign in_ready  = !skid_v_q;
  assign accept    = in_valid & in_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign sel_err   = err_q;
  // Select the indexed input; indices past NUM_IN never touch in_bus and yield DEFAULT
  always_comb begin
    sel_val = DEFAULT;
    sel_ok  = 1'b0;
    for (int k = 0; k < NUM_IN; k++)
      if (sel == SEL_W'(k)) begin
        sel_val = in_bus[k*WIDTH +: WIDTH];
        sel_ok  = 1'b1;
      end
  end
  // Main register has priority; skid only fills when main is full and stalled
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    err_d       = err_q | (accept & !sel_ok);
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_ready) begin
      main_v_d = skid_v_q | accept;
      if (skid_v_q) begin
        main_data_d = skid_data_q;
        main_sel_d  = skid_sel_q;
        skid_v_d    = 1'b0;
      end else if (accept) begin
        main_data_d = sel_val;
        main_sel_d  = sel;
      end
    end else if (accept) begin
      skid_v_d    = 1'b1;
      skid_data_d = sel_val;
      skid_sel_d  = sel;
    end
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_pipe_mux_skid.sv
// tb_pipe_mux_skid: directed checks of default, out-of-range and wide configurations
module tb_pipe_mux_skid;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [19:0] bus0 = {5'd31, 5'd17, 5'd9, 5'd3};
  logic [1:0]  s0 = '0, os0;
  logic        v0 = 0, f0 = 0, r0 = 1, ir0, ov0, e0;
  logic [4:0]  od0;
  logic [14:0] bus1 = {5'd17, 5'd9, 5'd3};
  logic [1:0]  s1 = '0, os1;
  logic        v1 = 0, f1 = 0, r1 = 1, ir1, ov1, e1;
  logic [4:0]  od1;
  logic [255:0] bus2 = '0;
  logic [2:0]  s2 = '0, os2;
  logic        v2 = 0, f2 = 0, r2 = 1, ir2, ov2, e2;
  logic [31:0] od2;
  int errors = 0, checks = 0;
  logic [34:0] sb[$];
  logic [34:0] exp_e;
  pipe_mux_skid u0 (.clk(clk), .reset(reset), .in_bus(bus0), .sel(s0), .in_valid(v0), .in_ready(ir0),
    .flush(f0), .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(r0), .sel_err(e0));
  pipe_mux_skid #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .DEFAULT(5'h1F)) u1 (.clk(clk), .reset(reset),
    .in_bus(bus1), .sel(s1), .in_valid(v1), .in_ready(ir1), .flush(f1), .out_data(od1), .out_sel(os1),
    .out_valid(ov1), .out_ready(r1), .sel_err(e1));
  pipe_mux_skid #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) u2 (.clk(clk), .reset(reset), .in_bus(bus2), .sel(s2),
    .in_valid(v2), .in_ready(ir2), .flush(f2), .out_data(od2), .out_sel(os2), .out_valid(ov2),
    .out_ready(r2), .sel_err(e2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick; tick;
    chk("rst_ov", ov0, 0); chk("rst_od", od0, 0); chk("rst_os", os0, 0);
    chk("rst_ir", ir0, 1); chk("rst_err", e0, 0);
    reset = 0;
    v0 = 1; s0 = 0; tick; chk("seq0_od", od0, 3);  chk("seq0_ov", ov0, 1); chk("seq0_ir", ir0, 1);
    s0 = 1;         tick; chk("seq1_od", od0, 9);  chk("seq1_ov", ov0, 1);
    s0 = 2;         tick; chk("seq2_od", od0, 17); chk("seq2_ir", ir0, 1);
    s0 = 3;         tick; chk("seq3_od", od0, 31); chk("seq3_os", os0, 3); chk("seq3_ov", ov0, 1);
    v0 = 0;         tick; chk("idle_ov", ov0, 0);  chk("idle_od", od0, 31);
    v0 = 1; s0 = 1; tick; chk("stl_a_od", od0, 9);
    r0 = 0; s0 = 2; tick; chk("stl_b_ir", ir0, 0); chk("stl_b_od", od0, 9); chk("stl_b_ov", ov0, 1);
    v0 = 0;         tick; chk("stl_c_od", od0, 9); chk("stl_c_os", os0, 1); chk("stl_c_ir", ir0, 0);
    r0 = 1;         tick; chk("stl_d_od", od0, 17); chk("stl_d_os", os0, 2); chk("stl_d_ir", ir0, 1);
    chk("stl_d_ov", ov0, 1);
    tick; chk("stl_e_ov", ov0, 0);
    r0 = 0; v0 = 1; s0 = 0; tick; chk("fl_a_od", od0, 3);
    s0 = 3;         tick; chk("fl_b_ir", ir0, 0); chk("fl_b_od", od0, 3);
    f0 = 1; s0 = 1; tick; chk("fl_c_ov", ov0, 0); chk("fl_c_ir", ir0, 1); chk("fl_c_od", od0, 3);
    chk("fl_c_os", os0, 0);
    f0 = 0; v0 = 0; r0 = 1; tick; chk("fl_d_ov", ov0, 0);
    tick; chk("fl_e_ov", ov0, 0); chk("fl_e_od", od0, 3);
    v1 = 1; s1 = 0; tick; chk("oor_a_od", od1, 3); chk("oor_a_err", e1, 0);
    s1 = 3;         tick; chk("oor_b_od", od1, 5'h1F); chk("oor_b_os", os1, 3); chk("oor_b_err", e1, 1);
    s1 = 2;         tick; chk("oor_c_od", od1, 17); chk("oor_c_err", e1, 1);
    v1 = 0; f1 = 1; tick; chk("oor_d_ov", ov1, 0); chk("oor_d_err", e1, 1);
    f1 = 0; v0 = 1; s0 = 2; v1 = 1; s1 = 1; tick;
    chk("ar_a_ov", ov0, 1); chk("ar_a_od", od0, 17); chk("ar_a_ov1", ov1, 1);
    #2 reset = 1; #1;
    chk("ar_b_ov", ov0, 0); chk("ar_b_od", od0, 0); chk("ar_b_ir", ir0, 1);
    chk("ar_b_err", e1, 0); chk("ar_b_ov1", ov1, 0);
    v1 = 0; s0 = 1;
    @(negedge clk); reset = 0;
    tick; chk("ar_c_od", od0, 9); chk("ar_c_ov", ov0, 1);
    v0 = 0; tick;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 8; k++) bus2[k*32 +: 32] = $urandom;
      v2 = 1'($urandom); s2 = 3'($urandom); r2 = 1'($urandom);
      if (ov2 && r2) begin
        if (sb.size() == 0) chk("wide_extra", {os2, od2}, 35'h7FFFFFFFF);
        else begin exp_e = sb.pop_front(); chk("wide_out", {os2, od2}, exp_e); end
      end
      if (v2 && ir2) sb.push_back({s2, bus2[s2*32 +: 32]});
      tick;
    end
    v2 = 0; r2 = 1;
    for (int c = 0; c < 4; c++) begin
      if (ov2) begin
        if (sb.size() == 0) chk("wide_extra", {os2, od2}, 35'h7FFFFFFFF);
        else begin exp_e = sb.pop_front(); chk("wide_out", {os2, od2}, exp_e); end
      end
      tick;
    end
    chk("wide_left", 35'(sb.size()), 0);
    chk("wide_err", e2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
